rename_unit: RTL and testbench
==============================

# rename_unit

Register-rename and dispatch stage sitting directly upstream of the issue queue. Each cycle it accepts at most one decoded ALU instruction, maps its architectural sources through a register alias table (RAT), allocates a fresh physical destination from a free list, and reads operand values or wakeup tags from an internal physical register file (PRF) and ready table. It then writes one entry into the issue queue. The issue queue's result broadcast is snooped to update the PRF and ready bits, with a same-cycle bypass so no wakeup is lost.

## Interface
- NUM_PHYS, 64: physical registers. Must be a power of two, 64..256. Tags are always carried as 8 bits.
- FL_DEPTH, NUM_PHYS-32: free-list capacity.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  decoded instruction present.
- dec_ready  out  1  instruction accepted this cycle.
- dec_alu_cmd  in  common::alu_cmd_t  ALU operation.
- dec_rs1, dec_rs2, dec_rd  in  5 each  architectural registers.
- dec_use_imm  in  1  op2 comes from dec_imm.
- dec_imm  in  32  sign-extended immediate.
- iq_full  in  1  issue queue full.
- iq_write_enable  out  1  write one issue-queue entry.
- iq_alu_cmd  out  common::alu_cmd_t  forwarded command.
- iq_op1, iq_op2  out  32 each  operand value, or {24'b0, tag} when not valid.
- iq_op1_valid, iq_op2_valid  out  1 each  operand holds data.
- iq_phys_rd  out  8  allocated destination; 0 when rd==x0.
- old_phys_rd  out  8  previous mapping of rd, for the future ROB.
- phys_result_valid  in  1  writeback broadcast valid.
- phys_result_tag  in  8  writeback physical register.
- phys_result_data  in  32  writeback value.
- free_valid  in  1  commit returns a physical register.
- free_preg  in  8  register being returned.

## Operation
- Accept condition: dec_ready = !iq_full && (fl_count != 0 || dec_rd == 0). The outputs are dec_ready = iq_write_enable = dec_valid && dec_ready.
- Rename is combinational within the accept cycle. All state updates at the posedge.
- Source lookup reads the RAT before this cycle's rd update, so rs==rd sees the old mapping.
- Operand resolution, in priority order:
  - src preg 0: value 0, valid.
  - phys_result_valid with matching tag: bypass phys_result_data, valid.
  - ready[p]: PRF[p], valid.
  - otherwise: {24'b0, p}, not valid.
- dec_use_imm: op2 = dec_imm, valid; rs2 is ignored.
- rd != 0 on accept:
  - Pop the free-list head.
  - RAT[rd] <= new preg; ready[new] <= 0.
  - old_phys_rd = previous RAT[rd].
- rd == 0: no pop; iq_phys_rd = 0, old_phys_rd = 0.
- Writeback: phys_result_valid with tag != 0 sets PRF[tag] <= data and ready[tag] <= 1.
- Free: free_valid with free_preg != 0 pushes onto the free-list tail.
  - Push when the free list is full is ignored; the bench flags it as an error.
- Free list: circular buffer, FL_DEPTH entries, with head, tail and fl_count.
  - Pointers wrap modulo FL_DEPTH.
  - Simultaneous push and pop: both take effect, fl_count is unchanged.
  - Push while empty with a pop request the same cycle: the pop is not granted that cycle (no push-to-pop bypass).
- PRF register 0 is hardwired 0 and ready.

## Timing
- Reset state:
  - RAT[i] = i for i in 0..31.
  - ready all 1; PRF all 0.
  - Free list holds 32..NUM_PHYS-1 in order, head at 32, fl_count = FL_DEPTH.
- Outputs during reset: iq_write_enable = 0, dec_ready = 0.
- Latency: zero-cycle decode-to-issue-queue write. The issue queue captures the entry at the same posedge that updates RAT and free list.
- Writeback becomes visible through the ready table one cycle later. The bypass covers the cycle of the broadcast itself.
- Handshake: no state change unless accepted. dec_* must hold while dec_valid && !dec_ready.
- rst asserted mid-stream discards all mappings and restores the reset state at the next posedge.

## Structure
- Add to common.sv: PHYS_TAG_W = 8, ARCH_REGS = 32, and typedef phys_tag_t.
- Sub-module free_list: a parameterised circular FIFO of phys_tag_t with reset-time initial contents, push/pop/empty/full/count.
- RAT, ready table and PRF stay in rename_unit.

## Test plan
- Reset, then rename add x1←x2,x3 -> iq_phys_rd=32, old_phys_rd=1, both operands valid with value 0, iq_write_enable=1.
- Back-to-back x1←x1+x1, then x2←x1+x1 -> second op1/op2 = {24'b0, 8'd32}, not valid.
- Broadcast tag 32 with data 0x55 in the same cycle as the second instruction -> both operands valid = 0x55 (bypass).
- iq_full=1 while dec_valid=1 -> dec_ready=0, no pop, RAT unchanged; on deassert the same instruction is accepted.
- 32 renames with no frees -> free list empty, dec_ready=0 for rd≠0 but 1 for rd=0. Then free_valid with preg 5 -> the next rename receives 5.
- Push and pop in the same cycle at wrap (head = FL_DEPTH-1) -> fl_count unchanged, pointers wrap to 0.

Source files
------------

// File: rtl/common.sv
`default_nettype none
// ============================================================================
// common : shared types and constants for the rename/dispatch slice
// Revision: 1.0
// ============================================================================
package common;

    localparam int PHYS_TAG_W = 8;
    localparam int ARCH_REGS  = 32;

    typedef logic [PHYS_TAG_W-1:0] phys_tag_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_cmd_t;

endpackage
`default_nettype wire

// File: rtl/rename_unit_free_list.sv
`default_nettype none
// ============================================================================
// free_list : circular FIFO of physical tags, preloaded at reset
// Revision: 1.0
// ============================================================================
module free_list
    import common::*;
#(
    parameter int DEPTH     = 32,
    parameter int INIT_BASE = 32,
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  phys_tag_t        push_data,
    input  logic             pop,
    output phys_tag_t        head_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    phys_tag_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign head_data = mem[head];
    // A push into an empty list is not visible to a pop in the same cycle.
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PHYS_TAG_W'(INIT_BASE + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
        end else begin
            if (push_ok) begin
                mem[tail] <= push_data;
                tail      <= next_ptr(tail);
            end
            if (pop_ok) begin
                head <= next_ptr(head);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rename_unit.sv
`default_nettype none
// ============================================================================
// rename_unit : RAT lookup, preg allocation, operand read and IQ dispatch
// Revision: 1.0
// ============================================================================
module rename_unit
    import common::*;
#(
    parameter int NUM_PHYS = 64,
    parameter int FL_DEPTH = NUM_PHYS - 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  alu_cmd_t    dec_alu_cmd,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_use_imm,
    input  logic [31:0] dec_imm,
    input  logic        iq_full,
    output logic        iq_write_enable,
    output alu_cmd_t    iq_alu_cmd,
    output logic [31:0] iq_op1,
    output logic [31:0] iq_op2,
    output logic        iq_op1_valid,
    output logic        iq_op2_valid,
    output phys_tag_t   iq_phys_rd,
    output phys_tag_t   old_phys_rd,
    input  logic        phys_result_valid,
    input  phys_tag_t   phys_result_tag,
    input  logic [31:0] phys_result_data,
    input  logic        free_valid,
    input  phys_tag_t   free_preg
);

    localparam int IDX_W = $clog2(NUM_PHYS);
    localparam int CNT_W = $clog2(FL_DEPTH + 1);

    phys_tag_t           rat [ARCH_REGS];
    logic [NUM_PHYS-1:0] ready;
    logic [31:0]         prf [NUM_PHYS];

    phys_tag_t           fl_head;
    logic                fl_empty;
    logic                fl_full;
    logic [CNT_W-1:0]    fl_count;
    logic                fl_push;
    logic                fl_pop;
    logic                has_rd;
    logic                accept;

    free_list #(
        .DEPTH     (FL_DEPTH),
        .INIT_BASE (ARCH_REGS)
    ) u_free_list (
        .clk       (clk),
        .rst       (rst),
        .push      (fl_push),
        .push_data (free_preg),
        .pop       (fl_pop),
        .head_data (fl_head),
        .empty     (fl_empty),
        .full      (fl_full),
        .count     (fl_count)
    );

    // Sources read the RAT before this cycle's rd update, so rs==rd sees the old preg.
    generate
        for (genvar s = 0; s < 2; s++) begin : g_src
            phys_tag_t   tag;
            logic [31:0] val;
            logic        ok;

            assign tag = (s == 0) ? rat[dec_rs1] : rat[dec_rs2];

            always_comb begin
                val = {24'b0, tag};
                ok  = 1'b0;
                if (tag == '0) begin
                    val = '0;
                    ok  = 1'b1;
                end else if (phys_result_valid && (phys_result_tag == tag)) begin
                    val = phys_result_data;
                    ok  = 1'b1;
                end else if (ready[tag[IDX_W-1:0]]) begin
                    val = prf[tag[IDX_W-1:0]];
                    ok  = 1'b1;
                end
            end
        end
    endgenerate

    assign has_rd          = (dec_rd != 5'd0);
    assign accept          = dec_valid && !rst && !iq_full && ((fl_count != '0) || !has_rd);
    assign dec_ready       = accept;
    assign iq_write_enable = accept;
    assign iq_alu_cmd      = dec_alu_cmd;
    assign iq_op1          = g_src[0].val;
    assign iq_op1_valid    = g_src[0].ok;
    assign iq_op2          = dec_use_imm ? dec_imm : g_src[1].val;
    assign iq_op2_valid    = dec_use_imm | g_src[1].ok;
    assign iq_phys_rd      = has_rd ? fl_head : '0;
    assign old_phys_rd     = has_rd ? rat[dec_rd] : '0;

    assign fl_pop  = accept && has_rd && !fl_empty;
    assign fl_push = free_valid && (free_preg != '0) && !fl_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i] <= PHYS_TAG_W'(i);
            end
            for (int i = 0; i < NUM_PHYS; i++) begin
                prf[i] <= '0;
            end
            ready <= '1;
        end else begin
            if (phys_result_valid && (phys_result_tag != '0)) begin
                prf[phys_result_tag[IDX_W-1:0]]   <= phys_result_data;
                ready[phys_result_tag[IDX_W-1:0]] <= 1'b1;
            end
            // Allocation follows writeback so a fresh preg always starts not-ready.
            if (fl_pop) begin
                rat[dec_rd]               <= fl_head;
                ready[fl_head[IDX_W-1:0]] <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rename_unit.sv
`default_nettype none
// ============================================================================
// tb_rename_unit : directed + random stimulus against a queue-based model
// Revision: 1.0
// ============================================================================
module tb_rename_unit;
    import common::*;

    localparam int NUM_PHYS = 64;
    localparam int FL_DEPTH = NUM_PHYS - 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic        dec_ready;
    alu_cmd_t    dec_alu_cmd;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_use_imm;
    logic [31:0] dec_imm;
    logic        iq_full;
    logic        iq_write_enable;
    alu_cmd_t    iq_alu_cmd;
    logic [31:0] iq_op1, iq_op2;
    logic        iq_op1_valid, iq_op2_valid;
    phys_tag_t   iq_phys_rd, old_phys_rd;
    logic        phys_result_valid;
    phys_tag_t   phys_result_tag;
    logic [31:0] phys_result_data;
    logic        free_valid;
    phys_tag_t   free_preg;

    rename_unit #(.NUM_PHYS(NUM_PHYS), .FL_DEPTH(FL_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_alu_cmd(dec_alu_cmd),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_imm(dec_use_imm), .dec_imm(dec_imm), .iq_full(iq_full),
        .iq_write_enable(iq_write_enable), .iq_alu_cmd(iq_alu_cmd),
        .iq_op1(iq_op1), .iq_op2(iq_op2),
        .iq_op1_valid(iq_op1_valid), .iq_op2_valid(iq_op2_valid),
        .iq_phys_rd(iq_phys_rd), .old_phys_rd(old_phys_rd),
        .phys_result_valid(phys_result_valid), .phys_result_tag(phys_result_tag),
        .phys_result_data(phys_result_data),
        .free_valid(free_valid), .free_preg(free_preg)
    );

    always #5 clk = ~clk;

    // Reference model: architectural map, ready/value per preg, free pool as a FIFO.
    int          rat_m [32];
    bit          rdy_m [NUM_PHYS];
    logic [31:0] prf_m [NUM_PHYS];
    int          fl_m [$];
    int          retired [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          last_valid = 0;
    bit          last_acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rat_m[i] = i;
        for (int i = 0; i < NUM_PHYS; i++) begin
            rdy_m[i] = 1'b1;
            prf_m[i] = '0;
        end
        fl_m.delete();
        for (int i = 32; i < NUM_PHYS; i++) fl_m.push_back(i);
        retired.delete();
    endtask

    function automatic void resolve(input int rs, output logic [31:0] v, output logic ok);
        int p;
        p = rat_m[rs];
        if (p == 0) begin
            v = '0; ok = 1'b1;
        end else if (phys_result_valid && (int'(phys_result_tag) == p)) begin
            v = phys_result_data; ok = 1'b1;
        end else if (rdy_m[p]) begin
            v = prf_m[p]; ok = 1'b1;
        end else begin
            v = 32'(p); ok = 1'b0;
        end
    endfunction

    task automatic set_dec(input bit v, input alu_cmd_t c, input int r1, input int r2,
                           input int rd, input bit ui, input logic [31:0] im);
        dec_valid   = v;
        dec_alu_cmd = c;
        dec_rs1     = 5'(r1);
        dec_rs2     = 5'(r2);
        dec_rd      = 5'(rd);
        dec_use_imm = ui;
        dec_imm     = im;
    endtask

    task automatic idle();
        set_dec(0, ALU_ADD, 0, 0, 0, 0, '0);
        iq_full           = 1'b0;
        phys_result_valid = 1'b0;
        phys_result_tag   = '0;
        phys_result_data  = '0;
        free_valid        = 1'b0;
        free_preg         = '0;
    endtask

    // Called just after a negedge with inputs applied; returns at the next negedge.
    task automatic step();
        bit          acc;
        int          exp_rd, exp_old, np;
        logic [31:0] v1, v2;
        logic        k1, k2;
        bit          full_before;
        #1;
        acc = !rst && dec_valid && !iq_full && (fl_m.size() != 0 || dec_rd == 0);
        check("dec_ready", 32'(dec_ready), 32'(acc));
        check("iq_write_enable", 32'(iq_write_enable), 32'(acc));
        exp_rd  = (dec_rd != 0 && fl_m.size() != 0) ? fl_m[0] : 0;
        exp_old = (dec_rd != 0) ? rat_m[dec_rd] : 0;
        if (acc) begin
            resolve(dec_rs1, v1, k1);
            if (dec_use_imm) begin
                v2 = dec_imm; k2 = 1'b1;
            end else begin
                resolve(dec_rs2, v2, k2);
            end
            check("iq_phys_rd", 32'(iq_phys_rd), 32'(exp_rd));
            check("old_phys_rd", 32'(old_phys_rd), 32'(exp_old));
            check("iq_op1", iq_op1, v1);
            check("iq_op1_valid", 32'(iq_op1_valid), 32'(k1));
            check("iq_op2", iq_op2, v2);
            check("iq_op2_valid", 32'(iq_op2_valid), 32'(k2));
            check("iq_alu_cmd", 32'(iq_alu_cmd), 32'(dec_alu_cmd));
        end
        last_valid = dec_valid;
        last_acc   = acc;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            full_before = (fl_m.size() == FL_DEPTH);
            if (phys_result_valid && phys_result_tag != 0) begin
                prf_m[phys_result_tag] = phys_result_data;
                rdy_m[phys_result_tag] = 1'b1;
            end
            if (acc && dec_rd != 0) begin
                np = fl_m.pop_front();
                if (exp_old != 0) retired.push_back(exp_old);
                rat_m[dec_rd] = np;
                rdy_m[np]     = 1'b0;
            end
            if (free_valid && free_preg != 0) begin
                if (full_before) begin
                    n_bad++;
                    $error("FAIL push_when_full: preg %0d pushed onto a full free list", free_preg);
                end else begin
                    fl_m.push_back(int'(free_preg));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drop_retired(input int p);
        for (int i = 0; i < retired.size(); i++) begin
            if (retired[i] == p) begin
                retired.delete(i);
                break;
            end
        end
    endtask

    initial begin
        int guard;
        int t;
        idle();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        // Reset: decoder presenting work must still see dec_ready low.
        set_dec(1, ALU_ADD, 2, 3, 1, 0, '0);
        step();
        step();
        rst = 1'b0;

        // add x1 <- x2, x3
        set_dec(1, ALU_ADD, 2, 3, 1, 0, '0);
        #1;
        check("tp_first_phys_rd", 32'(iq_phys_rd), 32'd32);
        check("tp_first_old_rd", 32'(old_phys_rd), 32'd1);
        check("tp_first_op1", iq_op1, 32'd0);
        check("tp_first_op_valid", {30'b0, iq_op1_valid, iq_op2_valid}, 32'd3);
        step();

        // x2 <- x1 + x1 sees the pending preg 32
        set_dec(1, ALU_ADD, 1, 1, 2, 0, '0);
        #1;
        check("tp_dep_op1", iq_op1, 32'd32);
        check("tp_dep_op1_valid", 32'(iq_op1_valid), 32'd0);
        step();

        // x3 <- x1 + x1 with a same-cycle broadcast of preg 32
        set_dec(1, ALU_OR, 1, 1, 3, 0, '0);
        phys_result_valid = 1'b1; phys_result_tag = 8'd32; phys_result_data = 32'h55;
        #1;
        check("tp_bypass_op1", iq_op1, 32'h55);
        check("tp_bypass_op2_valid", 32'(iq_op2_valid), 32'd1);
        step();
        phys_result_valid = 1'b0;

        // Next cycle the value comes from the PRF; op2 from immediate
        set_dec(1, ALU_ADD, 1, 9, 4, 1, 32'hFFFF_FFF0);
        step();

        // Issue queue stall, then the same instruction is accepted
        set_dec(1, ALU_SUB, 4, 2, 6, 0, '0);
        iq_full = 1'b1;
        step();
        step();
        iq_full = 1'b0;
        step();

        // Drain the free list
        guard = 0;
        set_dec(1, ALU_XOR, 5, 0, 5, 0, '0);
        while (fl_m.size() != 0 && guard < 100) begin
            step();
            guard++;
        end
        #1;
        check("tp_empty_rd_nz_ready", 32'(dec_ready), 32'd0);
        step();
        set_dec(1, ALU_AND, 1, 2, 0, 0, '0);
        #1;
        check("tp_empty_rd_zero_ready", 32'(dec_ready), 32'd1);
        step();

        // Free preg 5 while empty with a pop request: pop not granted this cycle
        set_dec(1, ALU_ADD, 1, 2, 7, 0, '0);
        free_valid = 1'b1; free_preg = 8'd5;
        drop_retired(5);
        #1;
        check("tp_no_push_pop_bypass", 32'(dec_ready), 32'd0);
        step();
        free_valid = 1'b0;
        #1;
        check("tp_reuse_freed", 32'(iq_phys_rd), 32'd5);
        step();

        // Seed two entries, then push+pop every cycle for more than one lap
        idle();
        for (int i = 0; i < 2; i++) begin
            free_valid = 1'b1; free_preg = phys_tag_t'(retired.pop_front());
            step();
        end
        for (int i = 0; i < FL_DEPTH + 4; i++) begin
            set_dec(1, ALU_ADD, $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(1, 31), 0, '0);
            free_valid = 1'b1; free_preg = phys_tag_t'(retired.pop_front());
            step();
        end
        idle();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            if (!(last_valid && !last_acc)) begin
                set_dec($urandom_range(0, 3) != 0, alu_cmd_t'($urandom_range(0, 9)),
                        $urandom_range(0, 31), $urandom_range(0, 31),
                        ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
                        $urandom_range(0, 3) == 0, $urandom);
            end
            iq_full = ($urandom_range(0, 4) == 0);
            free_valid = 1'b0; free_preg = '0;
            if (retired.size() != 0 && fl_m.size() < FL_DEPTH && $urandom_range(0, 2) != 0) begin
                free_valid = 1'b1; free_preg = phys_tag_t'(retired.pop_front());
            end
            phys_result_valid = 1'b0; phys_result_tag = '0; phys_result_data = '0;
            for (int k = 0; k < 4; k++) begin
                t = $urandom_range(1, NUM_PHYS - 1);
                if (!rdy_m[t] && !(fl_m.size() != 0 && fl_m[0] == t)) begin
                    phys_result_valid = 1'b1;
                    phys_result_tag   = phys_tag_t'(t);
                    phys_result_data  = $urandom;
                    break;
                end
            end
            step();
        end
        idle();

        // Mid-stream reset restores the initial mapping
        set_dec(1, ALU_ADD, 1, 2, 9, 0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("tp_post_reset_rd", 32'(iq_phys_rd), 32'd32);
        check("tp_post_reset_old", 32'(old_phys_rd), 32'd9);
        step();
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
